apb_arbiter_2to1: RTL and testbench

- Shares one downstream APB completer between two upstream APB requesters (m0, m1).
- Grants are round-robin and one transfer at a time.
- The arbiter re-runs a full APB SETUP/ACCESS sequence downstream for the granted requester.
- Non-granted requesters are stalled by holding their pready low.
- Sits between bus masters and an APB fabric or passthrough stage.

---
 rtl/apb_arbiter_2to1.sv | 122 ++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : apb_arbiter_2to1
// Brief    : Round-robin 2:1 APB arbiter; replays SETUP/ACCESS downstream for
//            the granted requester and stalls the other via pready low.
// Revision : 1.0
// ============================================================================
module apb_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pwdata,
    output logic                  m0_pready,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m1_pwdata,
    output logic                  m1_pready,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  outp_psel,
    output logic                  outp_penable,
    output logic                  outp_pwrite,
    output logic [ADDR_WIDTH-1:0] outp_paddr,
    output logic [DATA_WIDTH-1:0] outp_pwdata,
    input  logic                  outp_pready,
    input  logic [DATA_WIDTH-1:0] outp_prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   r_last_grant;
    logic   w_grant_nxt;
    logic   w_last_grant_nxt;
    logic   w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        outp_psel        = 1'b0;
        outp_penable     = 1'b0;
        w_done           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester not served last wins.
                if (m0_psel && m1_psel) begin
                    w_grant_nxt = ~r_last_grant;
                end else if (m0_psel) begin
                    w_grant_nxt = 1'b0;
                end else if (m1_psel) begin
                    w_grant_nxt = 1'b1;
                end
                if (m0_psel || m1_psel) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                outp_psel   = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                outp_psel    = 1'b1;
                outp_penable = 1'b1;
                if (outp_pready) begin
                    w_done           = 1'b1;
                    w_last_grant_nxt = r_grant;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        outp_pwrite = 1'b0;
        outp_paddr  = '0;
        outp_pwdata = '0;
        if (r_state != ST_IDLE) begin
            outp_pwrite = r_grant ? m1_pwrite : m0_pwrite;
            outp_paddr  = r_grant ? m1_paddr  : m0_paddr;
            outp_pwdata = r_grant ? m1_pwdata : m0_pwdata;
        end
    end

    // A requester that abandoned its transfer (psel/penable low) gets no pready.
    assign m0_pready = w_done & ~r_grant & m0_psel & m0_penable;
    assign m1_pready = w_done &  r_grant & m1_psel & m1_penable;

    assign m0_prdata = ((r_state == ST_ACCESS) && !r_grant) ? outp_prdata : '0;
    assign m1_prdata = ((r_state == ST_ACCESS) &&  r_grant) ? outp_prdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arbiter_2to1
// Brief    : Scoreboard bench for apb_arbiter_2to1 with directed APB traffic.
// Revision : 1.0
// ============================================================================
module tb_apb_arbiter_2to1;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic drop; } cmd_t;
    typedef struct { int m; logic [31:0] d; } rsp_t;
    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } ds_t;
    typedef struct { int wt; logic [31:0] d; } dsr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq_psel [2];
    logic        rq_pen  [2];
    logic        rq_pw   [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wdata[2];
    logic        m0_pready, m1_pready;
    logic [31:0] m0_prdata, m1_prdata;
    logic        outp_psel, outp_penable, outp_pwrite;
    logic [31:0] outp_paddr, outp_pwdata;
    logic        outp_pready;
    logic [31:0] outp_prdata;

    int   checks = 0;
    int   errors = 0;
    cmd_t cq0[$];
    cmd_t cq1[$];
    int   ph[2];
    logic drop_cur[2];
    logic done_s[2];
    rsp_t ers[$];
    ds_t  eds[$];
    dsr_t drs[$];
    logic ds_active;
    int   ds_cnt;
    dsr_t ds_cur;
    logic prev_done;

    always #5 clk = ~clk;

    apb_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_psel(rq_psel[0]), .m0_penable(rq_pen[0]), .m0_pwrite(rq_pw[0]),
        .m0_paddr(rq_addr[0]), .m0_pwdata(rq_wdata[0]),
        .m0_pready(m0_pready), .m0_prdata(m0_prdata),
        .m1_psel(rq_psel[1]), .m1_penable(rq_pen[1]), .m1_pwrite(rq_pw[1]),
        .m1_paddr(rq_addr[1]), .m1_pwdata(rq_wdata[1]),
        .m1_pready(m1_pready), .m1_prdata(m1_prdata),
        .outp_psel(outp_psel), .outp_penable(outp_penable), .outp_pwrite(outp_pwrite),
        .outp_paddr(outp_paddr), .outp_pwdata(outp_pwdata),
        .outp_pready(outp_pready), .outp_prdata(outp_prdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string info);
        checks++;
        errors++;
        $display("FAIL %s: %s", nm, info);
    endtask

    task automatic push_cmd(input int m, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic drop);
        cmd_t c;
        c.w = w; c.a = a; c.d = d; c.drop = drop;
        if (m == 0) cq0.push_back(c);
        else        cq1.push_back(c);
    endtask

    task automatic exp_ds(input logic w, input logic [31:0] a, input logic [31:0] d);
        ds_t e;
        e.w = w; e.a = a; e.d = d;
        eds.push_back(e);
    endtask

    task automatic exp_rsp(input int m, input logic [31:0] d);
        rsp_t e;
        e.m = m; e.d = d;
        ers.push_back(e);
    endtask

    task automatic ds_resp(input int wt, input logic [31:0] d);
        dsr_t e;
        e.wt = wt; e.d = d;
        drs.push_back(e);
    endtask

    task automatic get_cmd(input int m, output logic ok, output cmd_t c);
        ok = 1'b0;
        c.w = 1'b0; c.a = '0; c.d = '0; c.drop = 1'b0;
        if (m == 0 && cq0.size() > 0) begin c = cq0.pop_front(); ok = 1'b1; end
        if (m == 1 && cq1.size() > 0) begin c = cq1.pop_front(); ok = 1'b1; end
    endtask

    task automatic load_cmd(input int m, input cmd_t c);
        rq_psel[m]  = 1'b1;
        rq_pen[m]   = 1'b0;
        rq_pw[m]    = c.w;
        rq_addr[m]  = c.a;
        rq_wdata[m] = c.d;
        drop_cur[m] = c.drop;
        ph[m]       = 1;
    endtask

    // Requester model: SETUP one cycle, then hold ACCESS until pready.
    task automatic req_step(input int m);
        cmd_t c;
        logic ok;
        if (rst) begin
            rq_psel[m] = 1'b0;
            rq_pen[m]  = 1'b0;
            ph[m]      = 0;
        end else if (ph[m] == 0) begin
            get_cmd(m, ok, c);
            if (ok) load_cmd(m, c);
        end else if (ph[m] == 1) begin
            rq_pen[m] = 1'b1;
            ph[m]     = 2;
        end else if (done_s[m]) begin
            get_cmd(m, ok, c);
            if (ok) begin
                load_cmd(m, c);
            end else begin
                rq_psel[m] = 1'b0;
                rq_pen[m]  = 1'b0;
                ph[m]      = 0;
            end
        end else if (drop_cur[m]) begin
            rq_psel[m] = 1'b0;
            rq_pen[m]  = 1'b0;
            ph[m]      = 0;
        end
    endtask

    // Completer model; also drives a stray pready during SETUP.
    task automatic ds_step();
        if (rst || !outp_psel) begin
            ds_active   = 1'b0;
            outp_pready = 1'b0;
            outp_prdata = 32'hBAD0BAD0;
        end else if (!outp_penable) begin
            ds_active   = 1'b0;
            outp_pready = 1'b1;
            outp_prdata = 32'hBAD0BAD0;
        end else begin
            if (!ds_active) begin
                ds_active = 1'b1;
                ds_cnt    = 0;
                if (drs.size() > 0) begin
                    ds_cur = drs.pop_front();
                end else begin
                    ds_cur.wt = 0;
                    ds_cur.d  = '0;
                end
            end
            outp_pready = (ds_cnt >= ds_cur.wt);
            outp_prdata = ds_cur.d;
            ds_cnt++;
        end
    endtask

    task automatic drive_loop();
        forever begin
            @(negedge clk);
            done_s[0] = m0_pready;
            done_s[1] = m1_pready;
            @(posedge clk);
            #1;
            req_step(0);
            req_step(1);
            ds_step();
        end
    endtask

    task automatic monitor_loop();
        ds_t  e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("idle_gap_psel", 32'(outp_psel), 32'h0);
                prev_done = outp_psel && outp_penable && outp_pready;
                if (prev_done) begin
                    if (eds.size() == 0) begin
                        fail("unexpected_ds_xfer", $sformatf("addr %h", outp_paddr));
                    end else begin
                        e = eds.pop_front();
                        chk("ds_pwrite", 32'(outp_pwrite), 32'(e.w));
                        chk("ds_paddr", outp_paddr, e.a);
                        chk("ds_pwdata", outp_pwdata, e.d);
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    if ((m == 0) ? m0_pready : m1_pready) begin
                        if (ers.size() == 0) begin
                            fail("unexpected_pready", $sformatf("requester %0d", m));
                        end else begin
                            r = ers.pop_front();
                            chk("pready_who", 32'(m), 32'(r.m));
                            chk("prdata", (m == 0) ? m0_prdata : m1_prdata, r.d);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || ph[0] != 0 || ph[1] != 0 ||
                eds.size() > 0 || ers.size() > 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) fail("drain_timeout", $sformatf("eds=%0d ers=%0d", eds.size(), ers.size()));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_penable(input string nm);
        int n = 0;
        while (!outp_penable && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail(nm, "outp_penable never rose");
    endtask

    initial begin
        int pen_cycles;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            rq_psel[m] = 1'b0; rq_pen[m] = 1'b0; rq_pw[m] = 1'b0;
            rq_addr[m] = '0;   rq_wdata[m] = '0;
            ph[m] = 0; drop_cur[m] = 1'b0; done_s[m] = 1'b0;
        end
        outp_pready = 1'b0;
        outp_prdata = 32'hBAD0BAD0;
        ds_active   = 1'b0;
        ds_cnt      = 0;
        prev_done   = 1'b0;
        fork
            drive_loop();
            monitor_loop();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(outp_psel), 32'h0);
        chk("rst_penable", 32'(outp_penable), 32'h0);
        chk("rst_pwrite", 32'(outp_pwrite), 32'h0);
        chk("rst_paddr", outp_paddr, 32'h0);
        chk("rst_pwdata", outp_pwdata, 32'h0);
        chk("rst_m0_pready", 32'(m0_pready), 32'h0);
        chk("rst_m1_pready", 32'(m1_pready), 32'h0);
        chk("rst_m0_prdata", m0_prdata, 32'h0);
        chk("rst_m1_prdata", m1_prdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, zero wait states: checks cycle-exact latency.
        push_cmd(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        ds_resp(0, 32'h0);
        exp_ds(1'b1, 32'h10, 32'hDEADBEEF);
        exp_rsp(0, 32'h0);
        @(negedge clk);
        chk("t1_N_psel", 32'(outp_psel), 32'h0);
        @(negedge clk);
        chk("t1_N1_psel", 32'(outp_psel), 32'h1);
        chk("t1_N1_penable", 32'(outp_penable), 32'h0);
        chk("t1_N1_m0_pready", 32'(m0_pready), 32'h0);
        @(negedge clk);
        chk("t1_N2_penable", 32'(outp_penable), 32'h1);
        chk("t1_N2_paddr", outp_paddr, 32'h10);
        chk("t1_N2_pwdata", outp_pwdata, 32'hDEADBEEF);
        chk("t1_N2_m0_pready", 32'(m0_pready), 32'h1);
        chk("t1_N2_m1_pready", 32'(m1_pready), 32'h0);
        @(negedge clk);
        chk("t1_N3_psel", 32'(outp_psel), 32'h0);
        chk("t1_N3_m0_pready", 32'(m0_pready), 32'h0);
        wait_drain(50);

        // Read with three wait states from m1.
        push_cmd(1, 1'b0, 32'h20, 32'h0, 1'b0);
        ds_resp(3, 32'h12345678);
        exp_ds(1'b0, 32'h20, 32'h0);
        exp_rsp(1, 32'h12345678);
        wait_penable("t2_penable_timeout");
        pen_cycles = 0;
        while (outp_penable && pen_cycles < 20) begin
            pen_cycles++;
            @(negedge clk);
        end
        chk("t2_penable_cycles", 32'(pen_cycles), 32'd4);
        wait_drain(50);

        // Simultaneous requests: m1 was served last, so m0 goes first.
        push_cmd(0, 1'b1, 32'h30, 32'hA5A50001, 1'b0);
        push_cmd(1, 1'b1, 32'h34, 32'h5A5A0002, 1'b0);
        ds_resp(0, 32'h11110001);
        ds_resp(0, 32'h22220002);
        exp_ds(1'b1, 32'h30, 32'hA5A50001);
        exp_ds(1'b1, 32'h34, 32'h5A5A0002);
        exp_rsp(0, 32'h11110001);
        exp_rsp(1, 32'h22220002);
        wait_drain(50);

        // Continuous contention: strict alternation m0,m1,m0,m1,m0,m1.
        for (int i = 0; i < 3; i++) begin
            push_cmd(0, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            push_cmd(1, 1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            ds_resp(i % 2, 32'hC000 + 32'(2 * i));
            ds_resp(0, 32'hC000 + 32'(2 * i + 1));
            exp_ds(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            exp_ds(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
            exp_rsp(0, 32'hC000 + 32'(2 * i));
            exp_rsp(1, 32'hC000 + 32'(2 * i + 1));
        end
        wait_drain(200);

        // m0 drops psel during ACCESS: downstream completes, no pready to m0.
        push_cmd(0, 1'b1, 32'h40, 32'hCAFE0000, 1'b1);
        ds_resp(2, 32'h0BADF00D);
        exp_ds(1'b1, 32'h40, 32'hCAFE0000);
        wait_drain(50);
        chk("t5_idle_psel", 32'(outp_psel), 32'h0);
        chk("t5_m0_pready", 32'(m0_pready), 32'h0);

        // Reset in ACCESS (m0 completed last), then a tie must still go to m0.
        push_cmd(1, 1'b0, 32'h50, 32'h0, 1'b0);
        ds_resp(10, 32'hFEEDFACE);
        wait_penable("t6_penable_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_psel", 32'(outp_psel), 32'h0);
        chk("t6_rst_penable", 32'(outp_penable), 32'h0);
        chk("t6_rst_m0_pready", 32'(m0_pready), 32'h0);
        chk("t6_rst_m1_pready", 32'(m1_pready), 32'h0);
        chk("t6_rst_m1_prdata", m1_prdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        push_cmd(0, 1'b1, 32'h60, 32'h600D0001, 1'b0);
        push_cmd(1, 1'b1, 32'h64, 32'h600D0002, 1'b0);
        ds_resp(0, 32'h1);
        ds_resp(0, 32'h2);
        exp_ds(1'b1, 32'h60, 32'h600D0001);
        exp_ds(1'b1, 32'h64, 32'h600D0002);
        exp_rsp(0, 32'h1);
        exp_rsp(1, 32'h2);
        wait_drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
